// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads one word per start request over a
// req/ack memory port and hands it to the instruction register via ir_wr/ir_wr_ack.
module inst_fetch #(
    parameter int                       PA_DATA_WIDTH  = 32,
    parameter int                       PA_ADDR_WIDTH  = 32,
    parameter logic [PA_ADDR_WIDTH-1:0] PA_RESET_PC    = '0,
    parameter int                       PA_MEM_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    input  logic                     pc_ld,
    input  logic [PA_ADDR_WIDTH-1:0] pc_ld_val,
    output logic                     mem_rd_req,
    output logic [PA_ADDR_WIDTH-1:0] mem_addr,
    input  logic [PA_DATA_WIDTH-1:0] mem_rd_data,
    input  logic                     mem_rd_ack,
    output logic [PA_DATA_WIDTH-1:0] ir_data,
    output logic                     ir_wr,
    input  logic                     ir_wr_ack,
    output logic [PA_ADDR_WIDTH-1:0] pc,
    output logic                     busy,
    output logic                     fetch_done,
    output logic                     fetch_err
);

    localparam int                 CNT_W    = $clog2(PA_MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PA_MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WR_IR,
        S_WAIT_ACK
    } state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [PA_ADDR_WIDTH-1:0] pc_nxt;
    logic [PA_ADDR_WIDTH-1:0] pend_pc, pend_pc_nxt;
    logic                     pend_vld, pend_vld_nxt;
    logic [PA_DATA_WIDTH-1:0] ir_data_nxt;
    logic                     done_nxt, err_nxt;
    logic                     redir_vld;
    logic [PA_ADDR_WIDTH-1:0] redir_pc;

    // A redirect arriving in the exit cycle itself is the most recent one, so it wins.
    assign redir_vld = pend_vld | pc_ld;
    assign redir_pc  = pc_ld ? pc_ld_val : pend_pc;

    assign mem_addr = pc;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_nxt       = pc;
        pend_pc_nxt  = pend_pc;
        pend_vld_nxt = pend_vld;
        ir_data_nxt  = ir_data;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;

        if (state != S_IDLE && pc_ld) begin
            pend_vld_nxt = 1'b1;
            pend_pc_nxt  = pc_ld_val;
        end

        case (state)
            S_IDLE: begin
                if (pc_ld) begin
                    pc_nxt = pc_ld_val;
                end else if (fetch_en) begin
                    if (pc[1:0] == 2'b00) begin
                        state_nxt = S_REQ;
                        cnt_nxt   = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (mem_rd_ack) begin
                    ir_data_nxt = mem_rd_data;
                    state_nxt   = S_WR_IR;
                end else if (cnt == CNT_LAST) begin
                    state_nxt    = S_IDLE;
                    err_nxt      = 1'b1;
                    pend_vld_nxt = 1'b0;
                    if (redir_vld) pc_nxt = redir_pc;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WR_IR: begin
                state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ir_wr_ack) begin
                    state_nxt    = S_IDLE;
                    done_nxt     = 1'b1;
                    pend_vld_nxt = 1'b0;
                    pc_nxt       = redir_vld ? redir_pc : pc + PA_ADDR_WIDTH'(4);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Strobes are flopped from the next state so every output leaves a register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pc         <= PA_RESET_PC;
            pend_pc    <= '0;
            pend_vld   <= 1'b0;
            ir_data    <= '0;
            mem_rd_req <= 1'b0;
            ir_wr      <= 1'b0;
            busy       <= 1'b0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pc         <= pc_nxt;
            pend_pc    <= pend_pc_nxt;
            pend_vld   <= pend_vld_nxt;
            ir_data    <= ir_data_nxt;
            mem_rd_req <= (state_nxt == S_REQ);
            ir_wr      <= (state_nxt == S_WR_IR);
            busy       <= (state_nxt != S_IDLE);
            fetch_done <= done_nxt;
            fetch_err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory and IR responders, a transaction-level
// reference model compared every cycle, and directed scenarios with literal timings.
module tb_inst_fetch;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        pc_ld;
    logic [31:0] pc_ld_val;
    logic        mem_rd_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rd_data;
    logic        mem_rd_ack;
    logic [31:0] ir_data;
    logic        ir_wr;
    logic        ir_wr_ack;
    logic [31:0] pc;
    logic        busy;
    logic        fetch_done;
    logic        fetch_err;

    inst_fetch #(
        .PA_DATA_WIDTH (32),
        .PA_ADDR_WIDTH (32),
        .PA_RESET_PC   (32'h0000_0000),
        .PA_MEM_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (fetch_en),
        .pc_ld      (pc_ld),
        .pc_ld_val  (pc_ld_val),
        .mem_rd_req (mem_rd_req),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .mem_rd_ack (mem_rd_ack),
        .ir_data    (ir_data),
        .ir_wr      (ir_wr),
        .ir_wr_ack  (ir_wr_ack),
        .pc         (pc),
        .busy       (busy),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk) cyc++;

    // Memory responder: acks REQ cycle number mem_wait+1, data valid only with ack.
    // IR responder: acks three cycles after each ir_wr pulse and keeps a copy of the word.
    int          mem_wait     = 0;
    bit          mem_withhold = 1'b0;
    int          req_age      = 0;
    bit          ir_pend      = 1'b0;
    int          ir_age       = 0;
    logic [31:0] tb_ir        = '0;

    always @(posedge clk) begin
        #1;
        if (rst || !mem_rd_req) begin
            req_age     = 0;
            mem_rd_ack  = 1'b0;
            mem_rd_data = 32'hDEAD_BEEF;
        end else begin
            req_age++;
            if (!mem_withhold && req_age == mem_wait + 1) begin
                mem_rd_ack  = 1'b1;
                mem_rd_data = word_at(mem_addr);
            end else begin
                mem_rd_ack  = 1'b0;
                mem_rd_data = 32'hDEAD_BEEF;
            end
        end
        if (rst) begin
            ir_pend   = 1'b0;
            ir_wr_ack = 1'b0;
        end else if (ir_wr) begin
            ir_pend   = 1'b1;
            ir_age    = 0;
            ir_wr_ack = 1'b0;
            tb_ir     = ir_data;
        end else if (ir_wr_ack) begin
            ir_wr_ack = 1'b0;
            ir_pend   = 1'b0;
        end else if (ir_pend) begin
            ir_age++;
            ir_wr_ack = (ir_age == 3);
        end
    end

    // Reference model: what one fetch transaction must look like, advanced on each edge.
    typedef enum {M_IDLE, M_FETCH, M_WRITE, M_HANDOFF} mstage_t;
    mstage_t     m_stage   = M_IDLE;
    logic [31:0] m_pc      = '0;
    logic [31:0] m_ir      = '0;
    logic [31:0] m_pend_pc = '0;
    bit          m_pend    = 1'b0;
    bit          m_done    = 1'b0;
    bit          m_err     = 1'b0;
    int          m_tries   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_stage = M_IDLE;
            m_pc    = 32'h0;
            m_ir    = 32'h0;
            m_pend  = 1'b0;
            m_done  = 1'b0;
            m_err   = 1'b0;
            m_tries = 0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (m_stage != M_IDLE && pc_ld) begin
                m_pend    = 1'b1;
                m_pend_pc = pc_ld_val;
            end
            case (m_stage)
                M_IDLE: begin
                    if (pc_ld) m_pc = pc_ld_val;
                    else if (fetch_en) begin
                        if (m_pc % 4 == 0) begin
                            m_stage = M_FETCH;
                            m_tries = 0;
                        end else m_err = 1'b1;
                    end
                end
                M_FETCH: begin
                    m_tries++;
                    if (mem_rd_ack) begin
                        m_ir    = word_at(m_pc);
                        m_stage = M_WRITE;
                    end else if (m_tries == TMO) begin
                        m_stage = M_IDLE;
                        m_err   = 1'b1;
                        if (m_pend) m_pc = m_pend_pc;
                        m_pend  = 1'b0;
                    end
                end
                M_WRITE: m_stage = M_HANDOFF;
                M_HANDOFF: begin
                    if (ir_wr_ack) begin
                        m_stage = M_IDLE;
                        m_done  = 1'b1;
                        m_pc    = m_pend ? m_pend_pc : m_pc + 32'd4;
                        m_pend  = 1'b0;
                    end
                end
                default: m_stage = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc",         pc,         m_pc);
            check("mem_addr",   mem_addr,   m_pc);
            check("ir_data",    ir_data,    m_ir);
            check("mem_rd_req", 32'(mem_rd_req), 32'(m_stage == M_FETCH));
            check("ir_wr",      32'(ir_wr),      32'(m_stage == M_WRITE));
            check("busy",       32'(busy),       32'(m_stage != M_IDLE));
            check("fetch_done", 32'(fetch_done), 32'(m_done));
            check("fetch_err",  32'(fetch_err),  32'(m_err));
        end
    end

    // Observation counters used by the directed scenarios.
    int          req_cycles    = 0;
    int          busy_cycles   = 0;
    int          addr_unstable = 0;
    int          wr_cyc        = -1;
    logic [31:0] first_req_addr = '1;
    logic [31:0] req_addr       = '0;
    bit          prev_req       = 1'b0;

    always @(negedge clk) begin
        if (mem_rd_req === 1'b1) begin
            req_cycles++;
            if (!prev_req) first_req_addr = mem_addr;
            else if (mem_addr !== req_addr) addr_unstable++;
            req_addr = mem_addr;
        end
        if (busy === 1'b1) busy_cycles++;
        if (ir_wr === 1'b1) wr_cyc = cyc;
        prev_req = (mem_rd_req === 1'b1);
    end

    int t0;
    int end_cyc;
    bit end_done;

    task automatic start_fetch();
        fetch_en = 1'b1;
        t0       = cyc;
        @(negedge clk);
        fetch_en = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        end_cyc  = -1;
        end_done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (fetch_done === 1'b1 || fetch_err === 1'b1) begin
                end_cyc  = cyc;
                end_done = fetch_done;
                return;
            end
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_bound: no fetch_done/fetch_err within %0d cycles after cycle %0d", budget, t0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_ld     = 1'b1;
        pc_ld_val = v;
        @(negedge clk);
        pc_ld     = 1'b0;
    endtask

    int rq, bz, t_first;

    initial begin
        rst       = 1'b1;
        fetch_en  = 1'b0;
        pc_ld     = 1'b0;
        pc_ld_val = '0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset values
        check("rst_pc", pc, 32'h0);
        check("rst_ir_data", ir_data, 32'h0);
        check("rst_ctl", {27'd0, mem_rd_req, ir_wr, busy, fetch_done, fetch_err}, 32'h0);

        // Basic zero-wait fetch
        mem_wait = 0;
        start_fetch();
        wait_end(40);
        check("basic_done_cycle", end_cyc - t0, 6);
        check("basic_wr_cycle", wr_cyc - t0, 2);
        check("basic_addr", first_req_addr, 32'h0);
        check("basic_pc", pc, 32'h4);
        check("basic_ir", tb_ir, 32'h0000_0093);

        // Wait states and back-to-back
        do_reset();
        mem_wait      = 3;
        addr_unstable = 0;
        start_fetch();
        t_first = t0;
        wait_end(40);
        check("ws_done1_cycle", end_cyc - t_first, 9);
        start_fetch();
        wait_end(40);
        check("ws_done2_cycle", end_cyc - t_first, 18);
        check("ws_pc", pc, 32'h8);
        check("ws_addr_stable", addr_unstable, 0);

        // Redirect in IDLE beats fetch_en
        mem_wait  = 0;
        rq        = req_cycles;
        pc_ld     = 1'b1;
        pc_ld_val = 32'h100;
        fetch_en  = 1'b1;
        @(negedge clk);
        pc_ld     = 1'b0;
        fetch_en  = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_redir_pc", pc, 32'h100);
        check("idle_redir_noreq", req_cycles, rq);
        check("idle_redir_busy", 32'(busy), 32'h0);

        // Redirects during WAIT_ACK: last one wins
        start_fetch();
        repeat (2) @(negedge clk);
        pc_ld     = 1'b1;
        pc_ld_val = 32'h200;
        @(negedge clk);
        pc_ld_val = 32'h300;
        @(negedge clk);
        pc_ld     = 1'b0;
        wait_end(40);
        check("busy_redir_done", 32'(end_done), 32'h1);
        check("busy_redir_pc", pc, 32'h300);
        check("busy_redir_ir", tb_ir, 32'h0100_FEFF);

        // Timeout with ack withheld
        mem_withhold = 1'b1;
        start_fetch();
        wait_end(40);
        check("tmo_is_err", 32'(end_done), 32'h0);
        check("tmo_err_cycle", end_cyc - t0, TMO + 1);
        check("tmo_req_low", 32'(mem_rd_req), 32'h0);
        check("tmo_pc", pc, 32'h300);
        mem_withhold = 1'b0;

        // Ack in the last allowed REQ cycle is accepted
        mem_wait = TMO - 1;
        start_fetch();
        wait_end(40);
        check("tmo_last_done", 32'(end_done), 32'h1);
        check("tmo_last_cycle", end_cyc - t0, 9);
        check("tmo_last_pc", pc, 32'h304);

        // Misaligned PC
        mem_wait = 0;
        load_pc(32'h102);
        rq = req_cycles;
        bz = busy_cycles;
        start_fetch();
        wait_end(40);
        check("mis_is_err", 32'(end_done), 32'h0);
        check("mis_err_cycle", end_cyc - t0, 1);
        check("mis_no_req", req_cycles, rq);
        check("mis_no_busy", busy_cycles, bz);
        check("mis_pc", pc, 32'h102);

        // PC wrap
        load_pc(32'hFFFF_FFFC);
        start_fetch();
        wait_end(40);
        check("wrap_done_cycle", end_cyc - t0, 6);
        check("wrap_pc", pc, 32'h0);
        check("wrap_ir", tb_ir, 32'hFFFC_0003);

        // Reset during REQ
        load_pc(32'h500);
        mem_wait = 2;
        start_fetch();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_req_pc", pc, 32'h0);
        check("rst_req_ir", ir_data, 32'h0);
        check("rst_req_ctl", {27'd0, mem_rd_req, ir_wr, busy, fetch_done, fetch_err}, 32'h0);

        // Reset during WAIT_ACK with a pending redirect
        mem_wait = 0;
        start_fetch();
        repeat (2) @(negedge clk);
        pc_ld     = 1'b1;
        pc_ld_val = 32'h400;
        @(negedge clk);
        pc_ld     = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_wait_pc", pc, 32'h0);
        check("rst_wait_ir", ir_data, 32'h0);
        check("rst_wait_ctl", {27'd0, mem_rd_req, ir_wr, busy, fetch_done, fetch_err}, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_wait_no_late_done", 32'(fetch_done), 32'h0);
        start_fetch();
        wait_end(40);
        check("rst_pend_dropped_pc", pc, 32'h4);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
